// File: rtl/st_h2c_checker.sv
// H2C AXI-Stream receive/check engine: verifies the incrementing pattern and the
// per-packet byte count, counts packets and reports a sticky pass/fail result.
module st_h2c_checker #(
  parameter int BIT_WIDTH  = 64,
  parameter int PATT_WIDTH = 16,
  parameter int QID_BITS   = 11
) (
  input  logic                 axi_aclk,
  input  logic                 axi_aresetn,
  input  logic [31:0]          control_reg,
  input  logic [15:0]          txr_size,
  input  logic [10:0]          num_pkt,
  input  logic [BIT_WIDTH-1:0] h2c_tdata,
  input  logic                 h2c_tvalid,
  input  logic                 h2c_tlast,
  input  logic [5:0]           h2c_mty,
  input  logic [QID_BITS-1:0]  h2c_qid,
  output logic                 h2c_tready,
  output logic                 h2c_busy,
  output logic                 h2c_done,
  output logic                 h2c_match,
  output logic                 h2c_err_patt,
  output logic                 h2c_err_len,
  output logic [10:0]          h2c_pkt_count,
  output logic [QID_BITS-1:0]  h2c_qid_cap
);

  localparam int BYTES = BIT_WIDTH / 8;
  localparam int WORDS = BIT_WIDTH / PATT_WIDTH;

  typedef enum logic [2:0] {
    SM_IDLE      = 3'd0,
    SM_FIRST     = 3'd1,
    SM_PKT       = 3'd2,
    SM_PKT_START = 3'd3,
    SM_DONE      = 3'd4
  } state_t;

  state_t                state_r, state_nxt_s;
  logic                  arm_q_r, arm_qq_r;
  logic                  arm_edge_s, clear_s, bp_en_s, accept_s, first_beat_s;
  logic                  ctrl_unused_s;
  logic [PATT_WIDTH-1:0] word_base_r, word_base_nxt_s, word_start_s;
  logic [15:0]           byte_cnt_r, byte_cnt_nxt_s, byte_start_s;
  logic [6:0]            valid_bytes_s;
  logic [16:0]           len_total_s;
  logic [BIT_WIDTH-1:0]  exp_data_s;
  logic                  patt_bad_s;
  logic                  tready_r, tready_nxt_s;
  logic                  busy_r, busy_nxt_s;
  logic                  done_r, done_nxt_s;
  logic                  match_r, match_nxt_s;
  logic                  err_patt_r, err_patt_nxt_s;
  logic                  err_len_r, err_len_nxt_s;
  logic [10:0]           pkt_count_r, pkt_count_nxt_s;
  logic [QID_BITS-1:0]   qid_cap_r, qid_cap_nxt_s;

  assign clear_s       = control_reg[0];
  assign bp_en_s       = control_reg[2];
  assign ctrl_unused_s = ^control_reg[31:3];
  assign arm_edge_s    = arm_q_r & ~arm_qq_r;
  assign accept_s      = h2c_tvalid & tready_r;
  assign first_beat_s  = (state_r == SM_FIRST) || (state_r == SM_PKT_START);
  assign word_start_s  = first_beat_s ? {PATT_WIDTH{1'b0}} : word_base_r;
  assign byte_start_s  = first_beat_s ? 16'd0 : byte_cnt_r;
  assign len_total_s   = {1'b0, byte_start_s} + {10'd0, valid_bytes_s};

  assign h2c_tready    = tready_r;
  assign h2c_busy      = busy_r;
  assign h2c_done      = done_r;
  assign h2c_match     = match_r;
  assign h2c_err_patt  = err_patt_r;
  assign h2c_err_len   = err_len_r;
  assign h2c_pkt_count = pkt_count_r;
  assign h2c_qid_cap   = qid_cap_r;

  // Number of bytes in the current beat that carry payload.
  always_comb begin
    if (!h2c_tlast) begin
      valid_bytes_s = 7'(BYTES);
    end else if ({1'b0, h2c_mty} >= 7'(BYTES)) begin
      valid_bytes_s = 7'd0;
    end else begin
      valid_bytes_s = 7'(BYTES) - {1'b0, h2c_mty};
    end
  end

  // Byte-wise pattern compare so a partially valid word is checked on its valid bytes only.
  always_comb begin
    exp_data_s = {BIT_WIDTH{1'b0}};
    patt_bad_s = 1'b0;
    for (int i = 0; i < WORDS; i++) begin
      exp_data_s[i*PATT_WIDTH +: PATT_WIDTH] = word_start_s + PATT_WIDTH'(i);
    end
    for (int j = 0; j < BYTES; j++) begin
      if ((7'(j) < valid_bytes_s) && (h2c_tdata[j*8 +: 8] != exp_data_s[j*8 +: 8])) begin
        patt_bad_s = 1'b1;
      end else begin
        patt_bad_s = patt_bad_s;
      end
    end
  end

  // Next-state and next-status logic; clear dominates arm, arm dominates beat handling.
  always_comb begin
    state_nxt_s     = state_r;
    word_base_nxt_s = word_base_r;
    byte_cnt_nxt_s  = byte_cnt_r;
    pkt_count_nxt_s = pkt_count_r;
    qid_cap_nxt_s   = qid_cap_r;
    err_patt_nxt_s  = err_patt_r;
    err_len_nxt_s   = err_len_r;
    if (clear_s) begin
      state_nxt_s     = SM_IDLE;
      word_base_nxt_s = {PATT_WIDTH{1'b0}};
      byte_cnt_nxt_s  = 16'd0;
      pkt_count_nxt_s = 11'd0;
      qid_cap_nxt_s   = {QID_BITS{1'b0}};
      err_patt_nxt_s  = 1'b0;
      err_len_nxt_s   = 1'b0;
    end else if (arm_edge_s) begin
      state_nxt_s     = (num_pkt == 11'd0) ? SM_DONE : SM_FIRST;
      pkt_count_nxt_s = 11'd0;
      err_patt_nxt_s  = 1'b0;
      err_len_nxt_s   = 1'b0;
    end else begin
      case (state_r)
        SM_FIRST, SM_PKT, SM_PKT_START: begin
          if (accept_s) begin
            qid_cap_nxt_s   = (state_r == SM_FIRST) ? h2c_qid : qid_cap_r;
            err_patt_nxt_s  = err_patt_r | patt_bad_s;
            word_base_nxt_s = word_start_s + PATT_WIDTH'(WORDS);
            if (h2c_tlast) begin
              err_len_nxt_s   = err_len_r | (len_total_s != {1'b0, txr_size});
              byte_cnt_nxt_s  = 16'd0;
              pkt_count_nxt_s = pkt_count_r + 11'd1;
              state_nxt_s     = ((pkt_count_r + 11'd1) == num_pkt) ? SM_DONE : SM_PKT_START;
            end else begin
              // A packet longer than 64 KiB pins the counter and is already a length error.
              err_len_nxt_s  = err_len_r | len_total_s[16];
              byte_cnt_nxt_s = len_total_s[16] ? 16'hFFFF : len_total_s[15:0];
              state_nxt_s    = SM_PKT;
            end
          end else begin
            state_nxt_s = state_r;
          end
        end
        SM_IDLE, SM_DONE: state_nxt_s = state_r;
        default:          state_nxt_s = SM_IDLE;
      endcase
    end
  end

  // Derived outputs; back-pressure toggles tready while a run is in progress.
  always_comb begin
    busy_nxt_s  = (state_nxt_s == SM_FIRST) || (state_nxt_s == SM_PKT) ||
                  (state_nxt_s == SM_PKT_START);
    done_nxt_s  = (state_nxt_s == SM_DONE);
    match_nxt_s = done_nxt_s & ~(err_patt_nxt_s | err_len_nxt_s);
    if (busy_nxt_s && bp_en_s) begin
      tready_nxt_s = (busy_r && !arm_edge_s) ? ~tready_r : 1'b0;
    end else begin
      tready_nxt_s = 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_r <= SM_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Arm edge detector, datapath counters and registered status outputs.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      arm_q_r     <= 1'b0;
      arm_qq_r    <= 1'b0;
      word_base_r <= {PATT_WIDTH{1'b0}};
      byte_cnt_r  <= 16'd0;
      tready_r    <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      match_r     <= 1'b0;
      err_patt_r  <= 1'b0;
      err_len_r   <= 1'b0;
      pkt_count_r <= 11'd0;
      qid_cap_r   <= {QID_BITS{1'b0}};
    end else begin
      arm_q_r     <= control_reg[1] & ~clear_s;
      arm_qq_r    <= arm_q_r;
      word_base_r <= word_base_nxt_s;
      byte_cnt_r  <= byte_cnt_nxt_s;
      tready_r    <= tready_nxt_s;
      busy_r      <= busy_nxt_s;
      done_r      <= done_nxt_s;
      match_r     <= match_nxt_s;
      err_patt_r  <= err_patt_nxt_s;
      err_len_r   <= err_len_nxt_s;
      pkt_count_r <= pkt_count_nxt_s;
      qid_cap_r   <= qid_cap_nxt_s;
    end
  end

endmodule

// File: doc/st_h2c_checker.md
# st_h2c_checker

Host-to-card (H2C) AXI-Stream receive and check engine for the QDMA streaming example design; it is the receiving counterpart of the C2H pattern generator. It accepts H2C packets, checks every valid byte against the incrementing PATT_WIDTH-bit pattern, and checks each packet's length against the programmed transfer size. It counts packets, captures the queue ID, and reports a sticky pass/fail result to the user register block once the programmed number of packets has arrived.

## Interface
Parameters:
- BIT_WIDTH, 64: data beat width (64/128/256/512).
- PATT_WIDTH, 16: pattern word width (16 or 32).
- QID_BITS, 11: queue ID width.

Ports:
- axi_aclk  in  1  clock; all logic on the rising edge.
- axi_aresetn  in  1  reset, asynchronous and active-low.
- control_reg  in  32  bit 0 clear, bit 1 arm, bit 2 back-pressure enable.
- txr_size  in  16  expected bytes per packet.
- num_pkt  in  11  expected packets per run.
- h2c_tdata  in  BIT_WIDTH  stream data.
- h2c_tvalid  in  1  beat valid.
- h2c_tlast  in  1  last beat of packet.
- h2c_mty  in  6  empty bytes at the top of the last beat; ignored when tlast=0.
- h2c_qid  in  QID_BITS  queue ID, valid on every beat.
- h2c_tready  out  1  beat accept.
- h2c_busy  out  1  armed and not done.
- h2c_done  out  1  all num_pkt packets received.
- h2c_match  out  1  done with no error.
- h2c_err_patt  out  1  sticky pattern mismatch.
- h2c_err_len  out  1  sticky length mismatch.
- h2c_pkt_count  out  11  packets received this run.
- h2c_qid_cap  out  QID_BITS  qid of the first beat of the run.

## Operation
- Accept: a beat is accepted when h2c_tvalid & h2c_tready.
- W = BIT_WIDTH/PATT_WIDTH words per beat. Word i of beat n must equal (n*W+i) mod 2^PATT_WIDTH. The word counter restarts at 0 on the first beat of every packet.
- Last beat: only the low BIT_WIDTH/8 − h2c_mty bytes are checked. A partially valid word is compared only on its valid bytes.
- Length: a 16-bit byte counter accumulates BIT_WIDTH/8 per beat, or BIT_WIDTH/8 − mty on the tlast beat. A packet total ≠ txr_size sets err_len. If the counter exceeds 65535 before tlast, it saturates and sets err_len.
- State machine:
  - SM_IDLE: tready=1; beats are accepted and discarded with no checking. A rising edge of control_reg[1] (registered, 1-cycle delay) goes to SM_FIRST and clears pkt_count, the errors, and done.
  - SM_FIRST: on an accepted beat, capture qid and go to SM_PKT. If that beat is tlast, the packet is complete: apply the packet-end rules below.
  - SM_PKT: check each accepted beat. On tlast, pkt_count+1. Then go to SM_DONE if the new count equals num_pkt, else to SM_PKT_START.
  - SM_PKT_START: same as SM_PKT, but the word counter is at 0.
  - SM_DONE: done=1, match=~(err_patt|err_len). tready=1 and further beats are discarded. A new arm edge restarts the run.
- num_pkt = 0: the arm edge goes straight to SM_DONE with match=1.
- Clear (control_reg[0]=1): synchronously forces SM_IDLE and zeroes all status. Clear wins over a simultaneous arm.
- Arm mid-run: restarts the run; the packet in flight is counted from its next beat and so reports err_patt.
- Back-pressure (control_reg[2]=1, while busy): tready toggles each cycle, starting at 0 on the cycle after arm. Otherwise tready=1 whenever out of reset.

## Timing
- Reset values: tready 0, busy 0, done 0, match 0, err_patt 0, err_len 0, pkt_count 0, qid_cap 0, state SM_IDLE. tready rises on the first clock after reset release.
- Errors register 1 cycle after the offending beat is accepted.
- pkt_count updates 1 cycle after the tlast beat.
- done and match assert 1 cycle after the final tlast beat, together with the last pkt_count update. busy deasserts in the same cycle.
- All status is sticky until the next arm, clear, or reset.
- tvalid with tready=0 holds the beat. The checker must not advance on an unaccepted beat.
- Reset mid-packet: all state is lost. The packet remainder received after reset is discarded in SM_IDLE.

## Test plan
- BIT_WIDTH=64, txr_size=64, num_pkt=4, correct pattern, no back-pressure -> pkt_count=4, done=1, match=1, errors 0, done exactly 1 cycle after the 4th tlast.
- txr_size=70, last beat mty=2 with garbage in the top 2 bytes -> no errors, match=1. Repeat with mty=1 -> err_len=1, match=0.
- Word 5 of packet 2 corrupted (0x0005→0x0105) -> err_patt rises 1 cycle after that beat, stays sticky, and done arrives with match=0.
- Back-pressure enabled, tvalid held high for 3 packets of 256 bytes -> tready alternates, every beat is accepted exactly once, match=1.
- Arm and clear asserted in the same cycle -> stays SM_IDLE, all status 0. Then arm with num_pkt=0 -> done=1, match=1 two cycles later.
- axi_aresetn pulsed low mid-packet -> all outputs go to 0 immediately (asynchronously). After release, the remaining beats are discarded, and a new arm passes a clean 2-packet run.
